// File: rtl/ab_ram_pkg.sv
// Shared definitions for the clearable single-port RAM: clear-sequencer state encoding and legal read latencies.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ab_ram_pkg;

  // Clear sequencer states; busy is simply (state == CLEAR).
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // Read latency may be one or two clocks.
  localparam int RDLY_MIN = 1;
  localparam int RDLY_MAX = 2;

  function automatic bit rdly_legal(input int rdly);
    return (rdly == RDLY_MIN) || (rdly == RDLY_MAX);
  endfunction

endpackage

// File: rtl/ab_ram_clr_if.sv
// Host-side bus of the clearable RAM: access strobes, data in/out, clear request and busy.
// Latency: n/a (wires only).
// Backpressure: busy=1 means accesses presented on this bus are dropped, not stalled.
// Ports: cen/rw/a/ben/z_in/clr driven by the master; z_out/z_oe/busy driven by the RAM (slave).
interface ab_ram_clr_if #(
  parameter int DW = 16,
  parameter int AW = 9
);
  logic            cen;    // chip enable, active-low
  logic            rw;     // 1 = read, 0 = write
  logic [AW-1:0]   a;      // word address
  logic [DW/8-1:0] ben;    // byte-lane write enables, active-low, ben[i] -> bits 8i+7..8i
  logic [DW-1:0]   z_in;   // write data
  logic [DW-1:0]   z_out;  // read data
  logic [DW-1:0]   z_oe;   // per-bit output enable
  logic            clr;    // request to zero the whole array
  logic            busy;   // clear sweep in progress

  modport master (
    output cen, rw, a, ben, z_in, clr,
    input  z_out, z_oe, busy
  );

  modport slave (
    input  cen, rw, a, ben, z_in, clr,
    output z_out, z_oe, busy
  );
endinterface

// File: rtl/ab_ram_clr_seq.sv
// Clear sequencer: walks every address once, one word per clock, driving an all-zero write.
// Latency: busy rises the edge after clr is seen in IDLE; a sweep lasts exactly 2^AW clocks.
// Backpressure: clr is ignored while a sweep is running; no stall towards the requester.
// Ports: sys_clk, resetl (async, active-low), clr in; busy, clr_we, clr_addr out.
module ab_ram_clr_seq
  import ab_ram_pkg::*;
#(
  parameter int AW         = 9,
  parameter int CLR_ON_RST = 1
) (
  input  logic          sys_clk,
  input  logic          resetl,
  input  logic          clr,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  // Reset parks the sequencer in CLEAR so the sweep starts on the first edge after release.
  localparam clr_state_t RST_STATE = (CLR_ON_RST != 0) ? CLEAR : IDLE;

  clr_state_t    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        // clr is deliberately not looked at here: a running sweep is never restarted.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {AW{1'b1}}) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // busy comes straight from the state flop, so it is glitch-free.
  assign busy     = (state_q == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/ab_ram_clr.sv
// Single-port RAM with byte-lane writes, read-before-write pipeline and a whole-array clear sweep.
// Latency: read data on z_out after the RDLY-th edge (accepting edge = edge 1); one access per clock.
// Backpressure: while busy=1 accesses are dropped (no write, no z_oe); the host must hold off.
// Ports: sys_clk, resetl (async, active-low); bus (slave modport of ab_ram_clr_if) carries
//        cen/rw/a/ben/z_in/clr in and z_out/z_oe/busy out.
module ab_ram_clr
  import ab_ram_pkg::*;
#(
  parameter int DW         = 16,
  parameter int AW         = 9,
  parameter int RDLY       = 2,
  parameter int CLR_ON_RST = 1
) (
  input  logic         sys_clk,
  input  logic         resetl,
  ab_ram_clr_if.slave  bus
);

  localparam int NL    = DW / 8;
  localparam int DEPTH = 1 << AW;
  // An illegal latency falls back to the two-clock pipeline.
  localparam int RDLY_EFF = rdly_legal(RDLY) ? RDLY : RDLY_MAX;

  logic          busy;
  logic          clr_we;
  logic [AW-1:0] clr_addr;

  ab_ram_clr_seq #(
    .AW         (AW),
    .CLR_ON_RST (CLR_ON_RST)
  ) u_seq (
    .sys_clk  (sys_clk),
    .resetl   (resetl),
    .clr      (bus.clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign bus.busy = busy;

  // ---------------------------------------------------------------------------
  // Storage (not reset; the clear sweep is the only way to initialise it)
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_word;
  logic [DW-1:0] wr_word;
  logic          acc;

  // The sweep owns the array while busy, so host and sweep writes never collide.
  assign acc     = !bus.cen && !busy;
  assign rd_word = mem[bus.a];

  // Merge enabled lanes of z_in over the current word.
  always_comb begin
    wr_word = rd_word;
    for (int i = 0; i < NL; i++) begin
      if (!bus.ben[i]) begin
        wr_word[i*8 +: 8] = bus.z_in[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (acc && !bus.rw) begin
      mem[bus.a] <= wr_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline. Every accepted access (read or write) captures the pre-write
  // word; only reads raise z_oe when that word reaches the output.
  // ---------------------------------------------------------------------------
  logic          s1_acc;
  logic          s1_rd;
  logic [DW-1:0] s1_dat;

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      s1_acc <= 1'b0;
      s1_rd  <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_acc <= acc;
      s1_rd  <= acc && bus.rw;
      if (acc) begin
        s1_dat <= rd_word;
      end
    end
  end

  // With RDLY=1 the output register loads straight from the array; otherwise from stage 1.
  logic          out_acc;
  logic          out_rd;
  logic [DW-1:0] out_dat;

  assign out_acc = (RDLY_EFF == 1) ? acc                  : s1_acc;
  assign out_rd  = (RDLY_EFF == 1) ? (acc && bus.rw)      : s1_rd;
  assign out_dat = (RDLY_EFF == 1) ? rd_word              : s1_dat;

  logic [DW-1:0] z_out_q;
  logic [DW-1:0] z_oe_q;

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      z_out_q <= '0;
      z_oe_q  <= '0;
    end else begin
      // z_out holds between accesses; z_oe is a single-cycle strobe per read.
      if (out_acc) begin
        z_out_q <= out_dat;
      end
      z_oe_q <= {DW{out_rd}};
    end
  end

  assign bus.z_out = z_out_q;
  assign bus.z_oe  = z_oe_q;

endmodule

// File: tb/tb_ab_ram_clr.sv
module tb_ab_ram_clr;

  localparam logic [15:0] ON  = 16'hffff;
  localparam logic [15:0] OFF = 16'h0000;

  logic clk = 1'b0;
  logic resetl = 1'b0;
  always #5 clk = ~clk;

  ab_ram_clr_if #(.DW(16), .AW(9)) ifc2 ();
  ab_ram_clr_if #(.DW(16), .AW(9)) ifc1 ();

  ab_ram_clr #(.DW(16), .AW(9), .RDLY(2), .CLR_ON_RST(1)) u_d2 (
    .sys_clk (clk),
    .resetl  (resetl),
    .bus     (ifc2)
  );

  ab_ram_clr #(.DW(16), .AW(9), .RDLY(1), .CLR_ON_RST(1)) u_d1 (
    .sys_clk (clk),
    .resetl  (resetl),
    .bus     (ifc1)
  );

  typedef struct {
    logic        cen;
    logic        rw;
    logic [8:0]  a;
    logic [1:0]  ben;
    logic [15:0] d;
    logic        clr;
    logic [15:0] ez;
    logic [15:0] eoe;
    logic        eb;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic vec_t mk(input logic cen, input logic rw, input logic [8:0] a,
                              input logic [1:0] ben, input logic [15:0] d, input logic clr,
                              input logic [15:0] ez, input logic [15:0] eoe, input logic eb);
    vec_t v;
    v.cen = cen; v.rw = rw; v.a = a; v.ben = ben; v.d = d; v.clr = clr;
    v.ez = ez; v.eoe = eoe; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic idle_all();
    ifc1.cen = 1'b1; ifc1.rw = 1'b1; ifc1.a = '0; ifc1.ben = 2'b11; ifc1.z_in = '0; ifc1.clr = 1'b0;
    ifc2.cen = 1'b1; ifc2.rw = 1'b1; ifc2.a = '0; ifc2.ben = 2'b11; ifc2.z_in = '0; ifc2.clr = 1'b0;
  endtask

  // Drive one vector before an edge, check outputs on the following falling edge.
  task automatic apply(input vec_t v, input bit on1, input string tag, input int idx);
    if (on1) begin
      ifc1.cen = v.cen; ifc1.rw = v.rw; ifc1.a = v.a; ifc1.ben = v.ben; ifc1.z_in = v.d; ifc1.clr = v.clr;
    end else begin
      ifc2.cen = v.cen; ifc2.rw = v.rw; ifc2.a = v.a; ifc2.ben = v.ben; ifc2.z_in = v.d; ifc2.clr = v.clr;
    end
    @(posedge clk);
    @(negedge clk);
    if (on1) begin
      chk($sformatf("%s[%0d] z_out", tag, idx), ifc1.z_out, v.ez);
      chk($sformatf("%s[%0d] z_oe", tag, idx), ifc1.z_oe, v.eoe);
      chk($sformatf("%s[%0d] busy", tag, idx), {15'b0, ifc1.busy}, {15'b0, v.eb});
    end else begin
      chk($sformatf("%s[%0d] z_out", tag, idx), ifc2.z_out, v.ez);
      chk($sformatf("%s[%0d] z_oe", tag, idx), ifc2.z_oe, v.eoe);
      chk($sformatf("%s[%0d] busy", tag, idx), {15'b0, ifc2.busy}, {15'b0, v.eb});
    end
  endtask

  // Count edges until busy drops, bounded so a stuck sweep still ends the run.
  task automatic wait_idle(input int bound, output int n);
    n = 0;
    while (ifc2.busy && n < bound) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t tk[10];
  vec_t ta[21];
  vec_t tb[5];
  vec_t tc[3];
  vec_t td[2];
  int   n;

  initial begin
    idle_all();

    // RDLY=1 instance: three writes, three back-to-back reads, partial-lane write.
    tk[0] = mk(0, 0, 9'h000, 2'b00, 16'h1111, 0, 16'h0000, OFF, 0);
    tk[1] = mk(0, 0, 9'h001, 2'b00, 16'h2222, 0, 16'h0000, OFF, 0);
    tk[2] = mk(0, 0, 9'h002, 2'b00, 16'h3333, 0, 16'h0000, OFF, 0);
    tk[3] = mk(0, 1, 9'h000, 2'b11, 16'h0000, 0, 16'h1111, ON,  0);
    tk[4] = mk(0, 1, 9'h001, 2'b11, 16'h0000, 0, 16'h2222, ON,  0);
    tk[5] = mk(0, 1, 9'h002, 2'b11, 16'h0000, 0, 16'h3333, ON,  0);
    tk[6] = mk(1, 1, 9'h000, 2'b11, 16'h0000, 0, 16'h3333, OFF, 0);
    tk[7] = mk(0, 0, 9'h002, 2'b01, 16'hAAAA, 0, 16'h3333, OFF, 0);
    tk[8] = mk(0, 1, 9'h002, 2'b11, 16'h0000, 0, 16'hAA33, ON,  0);
    tk[9] = mk(1, 1, 9'h000, 2'b11, 16'h0000, 0, 16'hAA33, OFF, 0);

    // RDLY=2 instance: cleared read, A5C3 round trip, lane merge, throughput, clr with read.
    ta[0]  = mk(0, 1, 9'h1A7, 2'b11, 16'h0000, 0, 16'h0000, OFF, 0);
    ta[1]  = mk(1, 1, 9'h000, 2'b11, 16'h0000, 0, 16'h0000, ON,  0);
    ta[2]  = mk(0, 0, 9'h055, 2'b00, 16'hA5C3, 0, 16'h0000, OFF, 0);
    ta[3]  = mk(0, 1, 9'h055, 2'b11, 16'h0000, 0, 16'h0000, OFF, 0);
    ta[4]  = mk(1, 1, 9'h000, 2'b11, 16'h0000, 0, 16'hA5C3, ON,  0);
    ta[5]  = mk(1, 1, 9'h000, 2'b11, 16'h0000, 0, 16'hA5C3, OFF, 0);
    ta[6]  = mk(0, 0, 9'h010, 2'b00, 16'h1234, 0, 16'hA5C3, OFF, 0);
    ta[7]  = mk(0, 0, 9'h010, 2'b10, 16'hFFFF, 0, 16'h0000, OFF, 0);
    ta[8]  = mk(0, 1, 9'h010, 2'b11, 16'h0000, 0, 16'h1234, OFF, 0);
    ta[9]  = mk(1, 1, 9'h000, 2'b11, 16'h0000, 0, 16'h12FF, ON,  0);
    ta[10] = mk(1, 1, 9'h000, 2'b11, 16'h0000, 0, 16'h12FF, OFF, 0);
    ta[11] = mk(0, 1, 9'h055, 2'b11, 16'h0000, 0, 16'h12FF, OFF, 0);
    ta[12] = mk(0, 1, 9'h010, 2'b11, 16'h0000, 0, 16'hA5C3, ON,  0);
    ta[13] = mk(0, 1, 9'h1A7, 2'b11, 16'h0000, 0, 16'h12FF, ON,  0);
    ta[14] = mk(1, 1, 9'h000, 2'b11, 16'h0000, 0, 16'h0000, ON,  0);
    ta[15] = mk(1, 1, 9'h000, 2'b11, 16'h0000, 0, 16'h0000, OFF, 0);
    ta[16] = mk(0, 0, 9'h020, 2'b00, 16'hBEEF, 0, 16'h0000, OFF, 0);
    ta[17] = mk(0, 1, 9'h020, 2'b11, 16'h0000, 1, 16'h0000, OFF, 1);
    ta[18] = mk(0, 0, 9'h030, 2'b00, 16'hFFFF, 0, 16'hBEEF, ON,  1);
    ta[19] = mk(0, 1, 9'h020, 2'b11, 16'h0000, 1, 16'hBEEF, OFF, 1);
    ta[20] = mk(0, 0, 9'h000, 2'b00, 16'hFFFF, 0, 16'hBEEF, OFF, 1);

    // After the sweep: writes issued while busy left nothing behind.
    tb[0] = mk(0, 1, 9'h030, 2'b11, 16'h0000, 0, 16'hBEEF, OFF, 0);
    tb[1] = mk(0, 1, 9'h020, 2'b11, 16'h0000, 0, 16'h0000, ON,  0);
    tb[2] = mk(0, 1, 9'h000, 2'b11, 16'h0000, 0, 16'h0000, ON,  0);
    tb[3] = mk(1, 1, 9'h000, 2'b11, 16'h0000, 0, 16'h0000, ON,  0);
    tb[4] = mk(1, 1, 9'h000, 2'b11, 16'h0000, 0, 16'h0000, OFF, 0);

    // Marker above the abort point, then start a sweep alongside a read of it.
    tc[0] = mk(0, 0, 9'h150, 2'b00, 16'h5A5A, 0, 16'h0000, OFF, 0);
    tc[1] = mk(0, 1, 9'h150, 2'b11, 16'h0000, 1, 16'h0000, OFF, 1);
    tc[2] = mk(1, 1, 9'h000, 2'b11, 16'h0000, 0, 16'h5A5A, ON,  1);

    td[0] = mk(0, 1, 9'h150, 2'b11, 16'h0000, 0, 16'h0000, OFF, 0);
    td[1] = mk(1, 1, 9'h000, 2'b11, 16'h0000, 0, 16'h0000, ON,  0);

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst z_out d2", ifc2.z_out, 16'h0000);
    chk("rst z_oe d2", ifc2.z_oe, OFF);
    chk("rst busy d2", {15'b0, ifc2.busy}, 16'h0001);
    chk("rst z_oe d1", ifc1.z_oe, OFF);
    chk("rst busy d1", {15'b0, ifc1.busy}, 16'h0001);

    // Power-on sweep: busy for exactly 512 edges.
    resetl = 1'b1;
    wait_idle(600, n);
    chk("por sweep length", 16'(n), 16'd512);
    chk("por busy d1", {15'b0, ifc1.busy}, 16'h0000);

    for (int i = 0; i < 10; i++) apply(tk[i], 1'b1, "rdly1", i);
    idle_all();
    for (int i = 0; i < 21; i++) apply(ta[i], 1'b0, "main", i);
    idle_all();

    // Sweep entered at ta[17]; three sweep edges already elapsed, clr at ta[19] ignored.
    wait_idle(600, n);
    chk("clr sweep remainder", 16'(n), 16'd509);
    for (int i = 0; i < 5; i++) apply(tb[i], 1'b0, "post", i);
    idle_all();

    for (int i = 0; i < 3; i++) apply(tc[i], 1'b0, "abort", i);
    idle_all();
    // tc[2] was sweep edge 1; 99 more reach sweep count 100.
    repeat (99) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("pre-abort busy", {15'b0, ifc2.busy}, 16'h0001);
    resetl = 1'b0;
    #1;
    chk("abort z_out", ifc2.z_out, 16'h0000);
    chk("abort z_oe", ifc2.z_oe, OFF);
    chk("abort busy", {15'b0, ifc2.busy}, 16'h0001);
    @(negedge clk);
    @(negedge clk);
    chk("abort busy held", {15'b0, ifc2.busy}, 16'h0001);
    resetl = 1'b1;
    wait_idle(600, n);
    chk("restart sweep length", 16'(n), 16'd512);
    for (int i = 0; i < 2; i++) apply(td[i], 1'b0, "restart", i);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
